shift_reg_ctrl: RTL and testbench
=================================

Name: shift_reg_ctrl

Overview:
Sequencer that loads a parallel word into an external shift_reg instance (WIDTH-bit, serial data_in, shift_en, direction) bit by bit at a programmable rate, then returns the register contents on an output handshake. It sits between a valid/ready word source and the shift register, driving all shift register controls. It is the only driver of those controls.

Parameters:
WIDTH, 10, shift register width and word width; minimum 2
DIV_W, 8, width of the bit-rate divider

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid & s_ready
s_data  in  WIDTH  word to shift in
s_msb_first  in  1  1: feed MSB first (shift left); 0: feed LSB first (shift right)
clk_div  in  DIV_W  idle cycles between shift pulses; sampled at accept
abort  in  1  synchronous abort, highest priority
sr_data_in  out  1  to shift_reg data_in
sr_shift_en  out  1  to shift_reg shift_en
sr_direction  out  1  to shift_reg direction
sr_data_out  in  WIDTH  from shift_reg data_out
m_valid  out  1  result valid
m_ready  in  1  result consumed when m_valid & m_ready
m_data  out  WIDTH  captured shift register contents
busy  out  1  state != IDLE
err  out  1  capture mismatch flag (see Optional Feature)

Behaviour:
- Reset: state IDLE; s_ready=1, sr_shift_en=0, sr_data_in=0, sr_direction=0, m_valid=0, m_data=0, busy=0, err=0. Internal word, bit counter and divider cleared.
- s_ready = (state==IDLE) & ~abort. All other outputs registered.
- States: IDLE, SHIFT, CAPT, DONE.
- IDLE: on accept, latch s_data, s_msb_first, and clk_div into div_reload; div_cnt<=clk_div, bit_cnt<=0; sr_direction<=s_msb_first; go SHIFT.
- SHIFT: if div_cnt!=0, decrement it; sr_shift_en=0. If div_cnt==0, assert sr_shift_en for exactly one cycle and reload div_cnt<=div_reload. sr_data_in = word[WIDTH-1-bit_cnt] if msb_first, else word[bit_cnt]. Increment bit_cnt per pulse. After pulse number WIDTH (bit_cnt==WIDTH-1 at pulse), go CAPT.
- Bit ordering guarantees shift_reg data_out == latched word after WIDTH pulses, for both directions.
- CAPT: one cycle; m_data<=sr_data_out; m_valid<=1; go DONE.
- DONE: hold m_valid and m_data until m_valid & m_ready, then m_valid<=0 and go IDLE. New word is accepted no earlier than the following cycle.
- Timing, clk_div=0: accept at edge 0; sr_shift_en high cycles 1..WIDTH; m_valid high from cycle WIDTH+2. General: pulse k (1..WIDTH) occurs in cycle k*(clk_div+1).
- sr_direction is held constant from accept until return to IDLE. sr_data_in is held between pulses.
- abort (any state): next cycle state IDLE, sr_shift_en=0, m_valid=0, bit_cnt=0. m_data and err retain their values. Shift register contents are not cleared. abort coincident with s_valid in IDLE: no accept.
- clk_div changes after accept have no effect on the current word.
- Reset mid-operation: all outputs return to reset values immediately (async).
- err holds its last value until the next CAPT.

Optional Feature:
- Macro SHIFT_REG_CTRL_CHECK_EN.
- Defined: in CAPT, err<=(sr_data_out != latched word). m_valid is still asserted on mismatch.
- Undefined: err is tied to 0, and no comparator or copy of the word is kept beyond what sequencing needs.

Test Plan:
- WIDTH=10, clk_div=0, s_msb_first=1, s_data=10'h2B5 -> sr_shift_en high cycles 1..10, sr_direction=1, sr_data_in=1,0,1,0,1,1,0,1,0,1; m_valid at cycle 12, m_data=10'h2B5.
- Same word, s_msb_first=0 -> sr_direction=0, sr_data_in=1,0,1,0,1,1,0,1,0,1 (LSB first); m_data=10'h2B5.
- clk_div=3, s_data=10'h3FF -> pulses at cycles 4,8,...,40, each one cycle wide; m_valid at cycle 42.
- m_ready held low 5 cycles in DONE -> m_valid and m_data stable, s_ready=0. m_ready=1 -> IDLE next cycle, back-to-back word accepted the cycle after.
- abort asserted after 4th pulse -> no further pulses, m_valid never set, s_ready=1 the next cycle. A new word then completes normally.
- With SHIFT_REG_CTRL_CHECK_EN defined, force sr_data_out bit 0 wrong at CAPT -> err=1, m_valid=1. Next clean word -> err=0.

Source files
------------

// File: rtl/shift_reg_ctrl.sv
// -----------------------------------------------------------------------------
// shift_reg_ctrl
//
// Sequencer that loads a parallel word into an external WIDTH-bit shift
// register one bit at a time, at a programmable bit rate, and then returns the
// shift register contents on a valid/ready output handshake. This block is
// the only driver of the shift register's data_in, shift_en and direction
// pins.
//
// Optional feature (compile-time macro SHIFT_REG_CTRL_CHECK_EN):
//   When defined, the value captured from the shift register is compared with
//   the word that was loaded, and err reports a mismatch. When undefined, err
//   is tied low and no comparator exists.
//
// Parameters:
//   WIDTH  shift register / word width (minimum 2)
//   DIV_W  width of the bit-rate divider
//
// Ports:
//   clk           clock
//   rst_n         asynchronous reset, active-low
//   s_valid       input word valid
//   s_ready       input word accepted when s_valid & s_ready (combinational)
//   s_data        word to shift in
//   s_msb_first   1: MSB first, shift left; 0: LSB first, shift right
//   clk_div       idle cycles between shift pulses, sampled at accept
//   abort         synchronous abort, highest priority
//   sr_data_in    serial bit to the shift register
//   sr_shift_en   one-cycle shift strobe to the shift register
//   sr_direction  shift direction to the shift register (1 = left)
//   sr_data_out   parallel contents from the shift register
//   m_valid       result valid
//   m_ready       result consumed when m_valid & m_ready
//   m_data        captured shift register contents
//   busy          sequencer is not idle
//   err           capture mismatch flag (optional feature, else 0)
// -----------------------------------------------------------------------------
module shift_reg_ctrl #(
    parameter int WIDTH = 10,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_msb_first,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             abort,
    output logic             sr_data_in,
    output logic             sr_shift_en,
    output logic             sr_direction,
    input  logic [WIDTH-1:0] sr_data_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy,
    output logic             err
);

    // Bit counter must be able to hold WIDTH: it reaches WIDTH during the
    // cycle in which the final shift pulse is on the wire.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg,      state_next;
    logic [WIDTH-1:0] word_reg,       word_next;
    logic             msb_first_reg,  msb_first_next;
    logic [DIV_W-1:0] div_reload_reg, div_reload_next;
    logic [DIV_W-1:0] div_cnt_reg,    div_cnt_next;
    logic [CW-1:0]    bit_cnt_reg,    bit_cnt_next;

    logic             sr_data_in_reg,   sr_data_in_next;
    logic             sr_shift_en_reg,  sr_shift_en_next;
    logic             sr_direction_reg, sr_direction_next;
    logic             m_valid_reg,      m_valid_next;
    logic [WIDTH-1:0] m_data_reg,       m_data_next;
    logic             busy_reg,         busy_next;

    // -------------------------------------------------------------------------
    // Serial bit selection.
    // MSB-first feeding reads the word from the top down. Rather than compute
    // WIDTH-1-bit_cnt at run time, a bit-reversed view of the word is wired up
    // so both orders are a plain index by bit_cnt.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] word_rev;
    logic             feed_bit;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign word_rev[gi] = word_reg[WIDTH-1-gi];
        end
    endgenerate

    // Only consumed while bit_cnt_reg < WIDTH.
    assign feed_bit = msb_first_reg ? word_rev[bit_cnt_reg] : word_reg[bit_cnt_reg];

    // -------------------------------------------------------------------------
    // Optional capture check
    // -------------------------------------------------------------------------
`ifdef SHIFT_REG_CTRL_CHECK_EN
    logic err_reg, err_next;
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign s_ready      = (state_reg == IDLE) && !abort;
    assign sr_data_in   = sr_data_in_reg;
    assign sr_shift_en  = sr_shift_en_reg;
    assign sr_direction = sr_direction_reg;
    assign m_valid      = m_valid_reg;
    assign m_data       = m_data_reg;
    assign busy         = busy_reg;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            word_reg         <= '0;
            msb_first_reg    <= 1'b0;
            div_reload_reg   <= '0;
            div_cnt_reg      <= '0;
            bit_cnt_reg      <= '0;
            sr_data_in_reg   <= 1'b0;
            sr_shift_en_reg  <= 1'b0;
            sr_direction_reg <= 1'b0;
            m_valid_reg      <= 1'b0;
            m_data_reg       <= '0;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            word_reg         <= word_next;
            msb_first_reg    <= msb_first_next;
            div_reload_reg   <= div_reload_next;
            div_cnt_reg      <= div_cnt_next;
            bit_cnt_reg      <= bit_cnt_next;
            sr_data_in_reg   <= sr_data_in_next;
            sr_shift_en_reg  <= sr_shift_en_next;
            sr_direction_reg <= sr_direction_next;
            m_valid_reg      <= m_valid_next;
            m_data_reg       <= m_data_next;
            busy_reg         <= busy_next;
        end
    end

`ifdef SHIFT_REG_CTRL_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        word_next         = word_reg;
        msb_first_next    = msb_first_reg;
        div_reload_next   = div_reload_reg;
        div_cnt_next      = div_cnt_reg;
        bit_cnt_next      = bit_cnt_reg;
        sr_data_in_next   = sr_data_in_reg;
        sr_shift_en_next  = 1'b0;
        sr_direction_next = sr_direction_reg;
        m_valid_next      = m_valid_reg;
        m_data_next       = m_data_reg;
`ifdef SHIFT_REG_CTRL_CHECK_EN
        err_next          = err_reg;
`endif

        unique case (state_reg)
            IDLE: begin
                if (s_valid && !abort) begin
                    word_next         = s_data;
                    msb_first_next    = s_msb_first;
                    div_reload_next   = clk_div;
                    div_cnt_next      = clk_div;
                    bit_cnt_next      = '0;
                    sr_direction_next = s_msb_first;
                    state_next        = SHIFT;
                end
            end

            SHIFT: begin
                if (bit_cnt_reg == CNT_FULL) begin
                    // The last pulse is on the wire this cycle; the shift
                    // register takes it on the coming edge, so its contents
                    // are final one cycle later, which is when CAPT samples.
                    state_next = CAPT;
                end else if (div_cnt_reg == '0) begin
                    sr_shift_en_next = 1'b1;
                    sr_data_in_next  = feed_bit;
                    div_cnt_next     = div_reload_reg;
                    bit_cnt_next     = bit_cnt_reg + 1'b1;
                end else begin
                    div_cnt_next = div_cnt_reg - 1'b1;
                end
            end

            CAPT: begin
                m_data_next  = sr_data_out;
                m_valid_next = 1'b1;
`ifdef SHIFT_REG_CTRL_CHECK_EN
                err_next     = (sr_data_out != word_reg);
`endif
                state_next   = DONE;
            end

            DONE: begin
                if (m_ready) begin
                    m_valid_next = 1'b0;
                    state_next   = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort wins over everything. m_data, err, sr_data_in and
        // sr_direction are deliberately left alone.
        if (abort) begin
            state_next       = IDLE;
            sr_shift_en_next = 1'b0;
            m_valid_next     = 1'b0;
            bit_cnt_next     = '0;
        end

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
module tb_shift_reg_ctrl;

    localparam int W  = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          s_msb_first;
    logic [DW-1:0] clk_div;
    logic          abort;
    logic          sr_data_in;
    logic          sr_shift_en;
    logic          sr_direction;
    logic [W-1:0]  sr_data_out;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          busy;
    logic          err;

    int vectors    = 0;
    int miscompares = 0;

    shift_reg_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_msb_first (s_msb_first),
        .clk_div     (clk_div),
        .abort       (abort),
        .sr_data_in  (sr_data_in),
        .sr_shift_en (sr_shift_en),
        .sr_direction(sr_direction),
        .sr_data_out (sr_data_out),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Model of the external shift register: left inserts at bit 0,
    // right inserts at the top bit. corrupt lets the bench inject a fault.
    logic [W-1:0] sr_q = '0;
    logic [W-1:0] corrupt = '0;
    assign sr_data_out = sr_q ^ corrupt;
    always @(posedge clk) begin
        if (sr_shift_en)
            sr_q <= sr_direction ? {sr_q[W-2:0], sr_data_in} : {sr_data_in, sr_q[W-1:1]};
    end

    // Expected values that persist across words.
    logic         exp_din   = 1'b0;
    logic [W-1:0] exp_mdata = '0;
    logic         exp_err   = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Present a word and pass the accept edge. Called away from the clock edge;
    // returns #1 after the accept edge with s_valid dropped and clk_div/s_data
    // scrambled (changes after accept must not matter).
    task automatic start_word(input logic [W-1:0] data, input logic msb, input logic [DW-1:0] div);
        s_data = data; s_msb_first = msb; clk_div = div; s_valid = 1'b1;
        chk("s_ready_before_accept", {{(W-1){1'b0}}, s_ready}, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        clk_div = DW'($urandom_range(0, 255));
        s_data  = W'($urandom);
        s_msb_first = ~msb;
        $display("word data=%03h msb_first=%0d clk_div=%0d", data, msb, div);
    endtask

    // Full transaction: pulse k expected at cycle k*(div+1), m_valid from
    // cycle W*(div+1)+2, m_ready held off for hold cycles in DONE.
    task automatic run_word(input logic [W-1:0] data, input logic msb,
                            input logic [DW-1:0] div, input int hold, input logic [W-1:0] bad);
        int period, tv, k;
        logic exp_en;
        period = int'(div) + 1;
        tv     = W * period + 2;
        corrupt = bad;
        start_word(data, msb, div);
        for (int c = 0; c <= tv; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            k = c / period;
            exp_en = (c >= 1) && (c % period == 0) && (k <= W);
            if (exp_en) exp_din = msb ? data[W-k] : data[k-1];
            if (c == tv) begin
                exp_mdata = data ^ bad;
`ifdef SHIFT_REG_CTRL_CHECK_EN
                exp_err = (bad != '0);
`else
                exp_err = 1'b0;
`endif
            end
            chk("shift_en",  {{(W-1){1'b0}}, sr_shift_en},  {{(W-1){1'b0}}, exp_en});
            chk("data_in",   {{(W-1){1'b0}}, sr_data_in},   {{(W-1){1'b0}}, exp_din});
            chk("direction", {{(W-1){1'b0}}, sr_direction}, {{(W-1){1'b0}}, msb});
            chk("busy",      {{(W-1){1'b0}}, busy},         1);
            chk("s_ready",   {{(W-1){1'b0}}, s_ready},      0);
            chk("m_valid",   {{(W-1){1'b0}}, m_valid},      (c >= tv) ? 1 : 0);
            chk("m_data",    m_data, exp_mdata);
            chk("err",       {{(W-1){1'b0}}, err},          {{(W-1){1'b0}}, exp_err});
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_m_valid", {{(W-1){1'b0}}, m_valid}, 1);
            chk("hold_m_data",  m_data, exp_mdata);
            chk("hold_s_ready", {{(W-1){1'b0}}, s_ready}, 0);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        corrupt = '0;
        @(negedge clk);
        chk("ret_m_valid", {{(W-1){1'b0}}, m_valid}, 0);
        chk("ret_s_ready", {{(W-1){1'b0}}, s_ready}, 1);
        chk("ret_busy",    {{(W-1){1'b0}}, busy},    0);
        chk("ret_m_data",  m_data, exp_mdata);
        $display("done data=%03h m_data=%03h err=%0d", data, m_data, err);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"},  {{(W-1){1'b0}}, s_ready},      1);
        chk({tag, "_shift_en"}, {{(W-1){1'b0}}, sr_shift_en},  0);
        chk({tag, "_data_in"},  {{(W-1){1'b0}}, sr_data_in},   0);
        chk({tag, "_dir"},      {{(W-1){1'b0}}, sr_direction}, 0);
        chk({tag, "_m_valid"},  {{(W-1){1'b0}}, m_valid},      0);
        chk({tag, "_m_data"},   m_data, 0);
        chk({tag, "_busy"},     {{(W-1){1'b0}}, busy},         0);
        chk({tag, "_err"},      {{(W-1){1'b0}}, err},          0);
    endtask

    initial begin
        int period;
        logic [W-1:0] w;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_msb_first = 1'b0;
        clk_div = '0; abort = 1'b0; m_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed words from the plan
        run_word(10'h2B5, 1'b1, 8'd0, 0, '0);
        run_word(10'h2B5, 1'b0, 8'd0, 5, '0);
        run_word(10'h3FF, 1'b1, 8'd3, 0, '0);
        run_word(10'h001, 1'b0, 8'd1, 2, '0);   // back-to-back accept

        // Abort after the 4th pulse
        period = 3;
        start_word(10'h155, 1'b1, 8'd2);
        for (int c = 0; c <= 4 * period; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
        end
        chk("abort_4th_pulse", {{(W-1){1'b0}}, sr_shift_en}, 1);
        w = 10'h155;
        exp_din = w[W-4];
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_s_ready", {{(W-1){1'b0}}, s_ready}, 1);
        chk("abort_busy",    {{(W-1){1'b0}}, busy},    0);
        chk("abort_m_data",  m_data, exp_mdata);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("abort_no_pulse", {{(W-1){1'b0}}, sr_shift_en}, 0);
            chk("abort_no_valid", {{(W-1){1'b0}}, m_valid},     0);
            chk("abort_data_in",  {{(W-1){1'b0}}, sr_data_in},  {{(W-1){1'b0}}, exp_din});
        end
        $display("abort after 4th pulse");

        // abort coincident with s_valid in IDLE: no accept
        s_valid = 1'b1; s_data = 10'h0F0; abort = 1'b1;
        @(negedge clk);
        chk("abort_idle_s_ready", {{(W-1){1'b0}}, s_ready}, 0);
        @(posedge clk); #1;
        s_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", {{(W-1){1'b0}}, busy}, 0);
        $display("abort with s_valid in idle");

        // New word after abort completes normally
        run_word(10'h155, 1'b1, 8'd2, 1, '0);

        // Corrupted capture, then a clean word
        run_word(10'h2B5, 1'b1, 8'd0, 0, 10'h001);
        run_word(10'h0C3, 1'b0, 8'd0, 0, '0);

        // Randomized words
        for (int i = 0; i < 12; i++) begin
            run_word(W'($urandom), 1'($urandom), DW'($urandom_range(0, 5)),
                     int'($urandom_range(0, 3)), '0);
        end

        // Asynchronous reset mid-shift
        start_word(10'h3A7, 1'b1, 8'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        exp_din = 1'b0; exp_mdata = '0; exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("async reset mid-shift");
        run_word(10'h3A7, 1'b0, 8'd1, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
